// File: rtl/fir_stream_driver_if.sv
// Handshake bundle between the FIR stream driver and its environment: input sample
// stream, FIR controller start/done handshake, and output result stream.
interface fir_stream_driver_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              fir_ready;
  logic [DATA_W-1:0] fir_x;
  logic              fir_done;
  logic [OUT_W-1:0]  fir_y;

  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;

  // master: the driver block itself
  modport master (
    input  in_valid, in_data,
    output in_ready,
    output fir_ready, fir_x,
    input  fir_done, fir_y,
    output out_valid, out_data,
    input  out_ready
  );

  // slave: the sample source, FIR controller and result consumer
  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  fir_ready, fir_x,
    output fir_done, fir_y,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/fir_stream_driver.sv
// Initiator for the FIR pipeline controller: accepts a sample, pulses fir_ready, waits for
// fir_done and queues fir_y in a small output FIFO. Optional wait timeout: FIR_TIMEOUT_EN.
module fir_stream_driver #(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 32,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 1023
)(
  input  logic                clk,
  input  logic                rst,
  fir_stream_driver_if.master bus,
  output logic                busy,
  output logic [15:0]         sample_cnt,
  output logic                timeout_err
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("fir_stream_driver: OUT_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] fir_x_q;
  logic              fir_ready_q;
  logic [OUT_W-1:0]  mem [OUT_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              accept, push, pop;

  // Only IDLE accepts, and a slot is reserved for the whole pass, so checking the
  // count here is enough to make the later push always fit.
  assign bus.in_ready  = !rst && (state == IDLE) && (count < DEPTH_C);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = (state == WAIT) && bus.fir_done;
  assign pop           = (count != '0) && bus.out_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.fir_ready = fir_ready_q;
  assign bus.fir_x     = fir_x_q;

`ifdef FIR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_q;
  logic          expire;
  assign expire      = (wait_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fir_x_q     <= '0;
      fir_ready_q <= 1'b0;
      busy        <= 1'b0;
      sample_cnt  <= '0;
`ifdef FIR_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fir_x_q     <= bus.in_data;
            fir_ready_q <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          fir_ready_q <= 1'b0;
          state       <= WAIT;
`ifdef FIR_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        WAIT: begin
          // done on the expiry cycle still counts as a normal completion
          if (bus.fir_done) begin
            sample_cnt <= sample_cnt + 16'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
`ifdef FIR_TIMEOUT_EN
          else if (expire) begin
            // leaving WAIT without a push frees the reserved slot
            timeout_q <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          fir_ready_q <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.fir_y;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == DEPTH_C));

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: table of single passes plus hand sequences for
// backpressure, simultaneous push/pop, spurious done and reset mid-WAIT.
module tb_fir_stream_driver;
  localparam int DATA_W = 16, OUT_W = 32, OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] sample_cnt;
  logic        timeout_err;

  fir_stream_driver_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  fir_stream_driver #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .sample_cnt(sample_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One full pass; returns at the negedge after fir_done has been sampled.
  task automatic run_pass(input logic [15:0] x, input logic [31:0] y, input int dly,
                          input logic pop_at_done);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin chk("in_ready_wait", bus.in_ready, 1); return; end
    bus.in_valid = 1'b1; bus.in_data = x;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("fir_ready_issue", bus.fir_ready, 1);
    chk("fir_x", bus.fir_x, x);
    chk("busy_issue", busy, 1);
    @(negedge clk);
    chk("fir_ready_drop", bus.fir_ready, 0);
    repeat (dly - 1) @(negedge clk);
    bus.fir_done = 1'b1; bus.fir_y = y; bus.out_ready = pop_at_done;
    @(negedge clk);
    bus.fir_done = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] x;
    logic [31:0] y;
    int          dly;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{16'h0005, 32'h0000_0019, 6, 16'd1};
    vt[1] = '{16'hFFFF, 32'hFFFF_FFFF, 1, 16'd2};
    vt[2] = '{16'h8000, 32'h4000_0000, 3, 16'd3};
    vt[3] = '{16'h7FFF, 32'h3FFF_0001, 2, 16'd4};

    bus.in_valid = 0; bus.in_data = 0; bus.fir_done = 0; bus.fir_y = 0; bus.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_fir_ready", bus.fir_ready, 0);
    chk("rst_fir_x", bus.fir_x, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      run_pass(vt[i].x, vt[i].y, vt[i].dly, 1'b0);
      chk("vec_cnt", sample_cnt, vt[i].cnt);
      chk("vec_busy", busy, 0);
      pop_chk("vec_out", vt[i].y);
      chk("vec_empty", bus.out_valid, 0);
    end

    // backpressure: four results fill the FIFO, further accepts blocked
    for (int i = 0; i < 4; i++) run_pass(16'(16'h10 + i), 32'h100 + i, 2, 1'b0);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_busy", busy, 0);
    bus.in_valid = 1'b1; bus.in_data = 16'h0055;
    repeat (3) @(negedge clk);
    chk("bp_no_accept_busy", busy, 0);
    chk("bp_no_accept_fir_ready", bus.fir_ready, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", bus.out_data, 32'h100 + i);
      @(negedge clk);
      if (i == 0) chk("bp_resume", bus.in_ready, 1);
    end
    bus.out_ready = 1'b0;
    chk("bp_empty", bus.out_valid, 0);
    run_pass(16'h0014, 32'h104, 2, 1'b0);
    run_pass(16'h0015, 32'h105, 2, 1'b0);
    chk("bp_cnt", sample_cnt, 16'd10);
    pop_chk("bp_tail0", 32'h104);
    pop_chk("bp_tail1", 32'h105);

    // simultaneous push and pop with two entries queued
    run_pass(16'h0001, 32'hA1, 2, 1'b0);
    run_pass(16'h0002, 32'hA2, 2, 1'b0);
    run_pass(16'h0003, 32'hA3, 3, 1'b1);
    pop_chk("pp_head", 32'hA2);
    pop_chk("pp_next", 32'hA3);
    chk("pp_empty", bus.out_valid, 0);
    chk("pp_cnt", sample_cnt, 16'd13);

    // spurious done in IDLE, then in ISSUE
    bus.fir_done = 1'b1; bus.fir_y = 32'hDEAD;
    @(negedge clk);
    bus.fir_done = 1'b0;
    chk("sp_idle_out_valid", bus.out_valid, 0);
    chk("sp_idle_cnt", sample_cnt, 16'd13);
    bus.in_valid = 1'b1; bus.in_data = 16'h0033;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.fir_done = 1'b1; bus.fir_y = 32'hBAD;
    @(negedge clk);
    bus.fir_done = 1'b0;
    chk("sp_issue_out_valid", bus.out_valid, 0);
    chk("sp_issue_cnt", sample_cnt, 16'd13);
    chk("sp_issue_busy", busy, 1);
    bus.fir_done = 1'b1; bus.fir_y = 32'h77;
    @(negedge clk);
    bus.fir_done = 1'b0;
    pop_chk("sp_real", 32'h77);
    chk("sp_real_cnt", sample_cnt, 16'd14);

`ifdef FIR_TIMEOUT_EN
    bus.in_valid = 1'b1; bus.in_data = 16'h0021;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("to_busy_before", busy, 1);
    chk("to_err_before", timeout_err, 0);
    @(negedge clk);
    chk("to_busy_after", busy, 0);
    chk("to_err_after", timeout_err, 1);
    chk("to_no_push", bus.out_valid, 0);
    run_pass(16'h0022, 32'h22, 2, 1'b0);
    pop_chk("to_next", 32'h22);
    chk("to_cnt", sample_cnt, 16'd15);
    chk("to_sticky", timeout_err, 1);
    run_pass(16'h0007, 32'hC7, 2, 1'b0);
`else
    chk("no_timeout_err", timeout_err, 0);
    run_pass(16'h0007, 32'hC7, 2, 1'b0);
    chk("pre_rst_cnt", sample_cnt, 16'd15);
`endif

    // reset three cycles after fir_ready, one result queued
    bus.in_valid = 1'b1; bus.in_data = 16'h0099;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mr_fir_ready", bus.fir_ready, 1);
    repeat (3) @(negedge clk);
    chk("mr_busy_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_in_ready", bus.in_ready, 0);
    chk("mr_fir_ready0", bus.fir_ready, 0);
    chk("mr_fir_x", bus.fir_x, 0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_data", bus.out_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cnt", sample_cnt, 0);
    chk("mr_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.fir_done = 1'b1; bus.fir_y = 32'hEE;
    @(negedge clk);
    bus.fir_done = 1'b0;
    chk("mr_late_done_valid", bus.out_valid, 0);
    chk("mr_late_done_cnt", sample_cnt, 0);
    chk("mr_late_done_busy", busy, 0);
    run_pass(16'h0042, 32'h1234, 1, 1'b0);
    pop_chk("mr_after", 32'h1234);
    chk("mr_after_cnt", sample_cnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Initiator-side companion to the FIR pipeline controller; it produces the controller's handshake.
- Accepts input samples on a valid/ready stream and presents each sample to the FIR datapath.
- Pulses `fir_ready` to start a filter pass, then waits for `fir_done`.
- Captures the filter result into a small output FIFO drained by a downstream valid/ready consumer.

Parameters:
- DATA_W, 16, width of input samples and `fir_x`.
- OUT_W, 32, width of FIR result `fir_y` and `out_data`.
- OUT_DEPTH, 4, output FIFO depth in entries (power of two, ≥2).
- TIMEOUT, 1023, max cycles to wait for `fir_done`; used only with FIR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_data  in  DATA_W  signed input sample.
- in_ready  out  1  driver accepts sample this cycle.
- fir_ready  out  1  start pulse to FIR controller.
- fir_x  out  DATA_W  sample held for FIR datapath.
- fir_done  in  1  FIR controller pass complete; one-cycle pulse.
- fir_y  in  OUT_W  FIR result, valid while `fir_done`=1.
- out_valid  out  1  output FIFO non-empty.
- out_data  out  OUT_W  FIFO head entry.
- out_ready  in  1  consumer accepts head.
- busy  out  1  high in any state other than IDLE.
- sample_cnt  out  16  completed passes, wraps modulo 2^16.
- timeout_err  out  1  sticky timeout flag; tied 0 without FIR_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous): every output is 0; state IDLE; FIFO empty.
- State machine:
  - IDLE:
    - `in_ready` = (fifo_count < OUT_DEPTH), combinational.
    - On `in_valid` && `in_ready`: register `in_data` into `fir_x`; go to ISSUE.
    - `fir_x` holds its value until the next accept.
  - ISSUE:
    - `fir_ready`=1 for exactly this one cycle; go to WAIT.
  - WAIT:
    - `fir_ready`=0.
    - On `fir_done`=1: push `fir_y` into the FIFO, increment `sample_cnt`, go to IDLE.
- Ignoring `fir_done`:
  - `fir_done` in IDLE or ISSUE is ignored: no push, no count.
- Slot reservation:
  - The FIFO slot is reserved at accept time.
  - Only pops occur before the push, so the push never overflows.
  - A push when full is impossible by construction. Assert this in simulation.
- Throughput: minimum 3 cycles per sample (accept, ISSUE, done in WAIT).
  - A 1-cycle gap after `fir_done` guarantees the controller is back in its idle state before the next `fir_ready`.
- FIFO:
  - `out_valid` = (count != 0); `out_data` = head, driven from a register.
  - Pop on `out_valid` && `out_ready`.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop from empty is a no-op.
  - Pointers wrap modulo OUT_DEPTH.
- `busy` = (state != IDLE).
- `sample_cnt`: 0xFFFF + 1 → 0x0000.
- Reset mid-operation (any state): return to IDLE, flush the FIFO, clear `sample_cnt`. Any result still in flight is discarded.

Optional Feature:
- Macro: FIR_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT without `fir_done`: set `timeout_err` (sticky until `rst`), return to IDLE, no push, `sample_cnt` unchanged.
  - The reserved FIFO slot is released.
  - `fir_done` in the same cycle the counter reaches TIMEOUT wins: normal push, no error.
- Undefined: no counter; WAIT is held indefinitely; `timeout_err` tied 0.

Test Plan:
- Single sample: `in_data`=0x0005 with `in_valid`; controller model returns `fir_done` 6 cycles after `fir_ready` with `fir_y`=0x0000_0019 → `fir_ready` high exactly 1 cycle, one cycle after accept; `out_data`=0x19 with `out_valid`; `sample_cnt`=1.
- Backpressure: `out_ready`=0; stream 6 samples → 4 results stored; `in_ready`=0 in IDLE after the 4th accept; asserting `out_ready` drains in order and resumes accepts.
- Simultaneous push/pop: FIFO count=2, `fir_done` in the same cycle as a pop → count stays 2; output order preserved.
- Spurious done: pulse `fir_done` while in IDLE → no push, `sample_cnt` unchanged.
- Reset mid-WAIT: assert `rst` 3 cycles after `fir_ready` with FIFO count=1 → all outputs 0 immediately; a later `fir_done` is ignored.
- FIR_TIMEOUT_EN defined, TIMEOUT=8: never return `fir_done` → `timeout_err`=1 after 8 WAIT cycles; state IDLE; next sample processes normally; `timeout_err` stays 1.
